// File: rtl/psum_buf.sv
// psum_buf: partial-sum buffer between input-channel passes of a convolution.
// Intermediate psums are held in a circular FIFO and replayed to the adder tree.
// On the final pass the adder result bypasses the FIFO and goes to a
// single-entry valid/ready output register instead.
//
// Ports
//   clk, rst             : clock and synchronous active-high reset
//   rd_en, first_pass    : adder requests stored psum (reads as 0 on first pass)
//   fifo_data            : registered psum to the adder tree
//   wr_en, wr_data       : adder result and its valid strobe
//   last_pass            : routes the result to the output stream
//   out_valid/out_data/out_ready : downstream handshake
//   full, empty, count   : buffer status (registered, post-update)
//   overflow, underflow  : sticky error flags, cleared only by rst
//
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module psum_buf #(
  parameter int DATA_WIDTH = 25,
  parameter int DEPTH      = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_en,
  input  logic                         first_pass,
  output logic signed [DATA_WIDTH-1:0] fifo_data,
  input  logic                         wr_en,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic                         last_pass,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  input  logic                         out_ready,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_rptr;
  logic [AW-1:0]         r_wptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_fifo_data;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic          w_rd_req;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_out_req;
  logic          w_out_load;
  logic          w_out_xfer;
  logic [CW-1:0] w_count_nxt;

  assign w_rd_req   = rd_en & ~first_pass;
  assign w_pop      = w_rd_req & (r_count != CNT_ZERO);
  assign w_push_req = wr_en & ~last_pass;
  // A pop in the same cycle frees a slot, so a full buffer still accepts.
  assign w_push     = w_push_req & ((r_count < CNT_DEPTH) | w_pop);
  assign w_out_req  = wr_en & last_pass;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_out_load = w_out_req & (~r_out_valid | out_ready);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CNT_ONE;
    else if (!w_push && w_pop)
      w_count_nxt = r_count - CNT_ONE;
  end

  // Storage is not reset; entries are invalidated by clearing the pointers.
  // Reading and writing the same slot in one cycle returns the old contents,
  // so there is no write-to-read bypass.
  always_ff @(posedge clk) begin
    if (w_push && !rst)
      r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr      <= '0;
      r_wptr      <= '0;
      r_count     <= '0;
      r_fifo_data <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_fifo_data <= w_pop ? r_mem[r_rptr] : '0;
      if (w_pop)
        r_rptr <= r_rptr + PTR_ONE;
      if (w_push)
        r_wptr <= r_wptr + PTR_ONE;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_DEPTH);
      r_empty <= (w_count_nxt == CNT_ZERO);
      if ((w_push_req && !w_push) || (w_out_req && !w_out_load))
        r_overflow <= 1'b1;
      if (w_rd_req && !w_pop)
        r_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_out_load) begin
      r_out_data  <= wr_data;
      r_out_valid <= 1'b1;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign fifo_data = r_fifo_data;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign count     = r_count;
  assign full      = r_full;
  assign empty     = r_empty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: doc/psum_buf.md
PSUM_BUF -- requirements
Module: psum_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 25, partial-sum width, matching the psum adder tree.
REQ-002 SHALL have parameter DEPTH, default 64, buffer entries; SHALL be a power of two and at least 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rd_en  input  1  adder requests the stored psum for the current pixel.
REQ-006 SHALL have port first_pass  input  1  first input-channel pass; stored psum reads as zero.
REQ-007 SHALL have port fifo_data  output  DATA_WIDTH  signed psum fed to the adder tree, registered.
REQ-008 SHALL have port wr_en  input  1  adder result valid.
REQ-009 SHALL have port wr_data  input  DATA_WIDTH  signed adder result.
REQ-010 SHALL have port last_pass  input  1  final pass; the result goes to the output stream, not the buffer.
REQ-011 SHALL have port out_valid  output  1  final psum available downstream.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  final psum.
REQ-013 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-014 SHALL have ports full and empty  output  1 each  buffer status, registered.
REQ-015 SHALL have port count  output  clog2(DEPTH)+1  occupied entries.
REQ-016 SHALL have ports overflow and underflow  output  1 each  sticky error flags.

Function
REQ-017 Buffer SHALL be a circular FIFO of DEPTH entries with read and write pointers of clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-018 When rd_en=1, first_pass=0 and count>0: fifo_data SHALL take mem[rptr] on the next edge (1-cycle latency); rptr SHALL increment; the entry SHALL be popped.
REQ-019 When rd_en=1 and first_pass=1: fifo_data SHALL become 0 next cycle; no pop; pointers SHALL be unchanged.
REQ-020 When rd_en=1, first_pass=0 and count=0: fifo_data SHALL become 0 and underflow SHALL set; there SHALL be no write-to-read bypass.
REQ-021 When rd_en=0: fifo_data SHALL become 0 next cycle.
REQ-022 When wr_en=1 and last_pass=0: wr_data SHALL be written at wptr and wptr incremented if count<DEPTH, or if a pop occurs in the same cycle.
REQ-023 Otherwise, under REQ-022 conditions, the data SHALL be dropped, overflow SHALL set, and wptr SHALL be unchanged.
REQ-024 count SHALL update as count + push - pop every cycle.
REQ-025 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both reflecting the post-update count.
REQ-026 When wr_en=1 and last_pass=1: the output register SHALL load wr_data and assert out_valid if out_valid=0 or out_ready=1.
REQ-027 Otherwise, under REQ-026 conditions, the data SHALL be dropped, overflow SHALL set, and out_data and out_valid SHALL be unchanged.
REQ-028 A transfer SHALL occur when out_valid and out_ready are both 1.
REQ-029 After a transfer with no new load, out_valid SHALL clear next cycle.
REQ-030 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-031 overflow and underflow SHALL remain set until rst.
REQ-032 Data SHALL pass through unmodified; no arithmetic, saturation or sign change.

Reset
REQ-033 While rst=1 at a clock edge: pointers, count, fifo_data, out_data, out_valid, overflow and underflow SHALL be 0; empty SHALL be 1 and full 0.
REQ-034 Reset SHALL take priority over all concurrent rd_en and wr_en activity.
REQ-035 Reset mid-operation SHALL discard buffered entries; mem contents need not be cleared.

Verification
REQ-036 Write 3 (first_pass) with wr_data 5,-7,100 and last_pass=0 -> count=3; then rd_en x3 with first_pass=0 -> fifo_data 5,-7,100, each one cycle after its rd_en; empty=1.
REQ-037 rd_en with first_pass=1 and count=2 -> fifo_data=0 and count stays 2.
REQ-038 Fill DEPTH=64 -> full=1; write without pop -> overflow=1, count=64. With full, pop and push in the same cycle -> count stays 64, no overflow, FIFO order preserved across pointer wrap.
REQ-039 rd_en on an empty buffer with first_pass=0 -> fifo_data=0, underflow=1; underflow stays 1 until rst.
REQ-040 Output handshake: last_pass writes of 11 and 22 with out_ready=0 -> out_data=11 held, 22 dropped, overflow=1. Then out_ready=1 -> 11 transfers and out_valid=0 next cycle.
REQ-041 Assert rst with count=10 and out_valid=1 -> next cycle all outputs are at their reset values; a subsequent write/read returns the new data only.
